// File: rtl/echo_pulse_meter_if.sv
// echo_pulse_meter_if
//  Bundles the request, echo and result signals of the echo pulse meter.
//  Signals:
//    start    request a measurement (one cycle)
//    echo     raw sensor echo, asynchronous to clk
//    busy     measurement in progress
//    done     one-cycle strobe, echo_us/dist_cm valid
//    timeout  one-cycle strobe, measurement aborted
//    echo_us  measured echo high time in us
//    dist_cm  echo_us / CM_DIV, floor
//  Modports: master (requester/sensor side), slave (the meter).
interface echo_pulse_meter_if #(
  parameter int W = 16
);
  logic         start;
  logic         echo;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [W-1:0] echo_us;
  logic [W-1:0] dist_cm;

  modport master (
    output start, echo,
    input  busy, done, timeout, echo_us, dist_cm
  );

  modport slave (
    input  start, echo,
    output busy, done, timeout, echo_us, dist_cm
  );
endinterface

// File: rtl/echo_pulse_meter.sv
// echo_pulse_meter
//  Receive side of the ultrasonic ranging path. After an accepted start it waits
//  for the echo pulse, measures its high time in 1 us ticks, converts it to
//  centimetres by repeated subtraction and reports with a one-cycle done strobe.
//  A timeout strobe is raised when no rise or no fall arrives within TIMEOUT_US.
//  Ports:
//    clk  system clock (100 MHz nominal)
//    rst  asynchronous, active-high reset
//    bus  echo_pulse_meter_if.slave: start/echo in; busy/done/timeout,
//         echo_us/dist_cm out
module echo_pulse_meter #(
  parameter int TICK_DIV   = 100,
  parameter int TIMEOUT_US = 30000,
  parameter int CM_DIV     = 58,
  parameter int W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  echo_pulse_meter_if.slave    bus
);

  localparam int PW = $clog2(TICK_DIV + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    CONVERT,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;

  logic           echo_meta;
  logic           echo_s;
  logic           echo_d;
  logic           rise;
  logic           fall;

  logic [PW-1:0]  presc;
  logic           tick;

  logic [W-1:0]   us_cnt;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   echo_us_r;
  logic [W-1:0]   dist_cm_r;

  logic           at_limit;
  logic           accept;

  // Edges are taken on the synchronised echo so both edges see the same
  // two-clock latency and the measured width is not skewed.
  assign rise     = echo_s & ~echo_d;
  assign fall     = ~echo_s & echo_d;
  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign at_limit = (us_cnt == W'(TIMEOUT_US));
  assign accept   = bus.start & ~bus.busy;

  assign bus.echo_us = echo_us_r;
  assign bus.dist_cm = dist_cm_r;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (bus.start) state_nx = WAIT_RISE;
      WAIT_RISE: begin
        if (rise)          state_nx = MEASURE;
        else if (at_limit) state_nx = IDLE;
      end
      MEASURE: begin
        // A fall on the last allowed tick still counts as a valid echo.
        if (fall)          state_nx = CONVERT;
        else if (at_limit) state_nx = IDLE;
      end
      CONVERT:   if (rem < W'(CM_DIV)) state_nx = DONE;
      // busy is low in DONE, so a start here begins the next run directly.
      DONE:      state_nx = bus.start ? WAIT_RISE : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.timeout = 1'b0;
    unique case (state)
      WAIT_RISE: begin
        bus.busy    = 1'b1;
        bus.timeout = at_limit & ~rise;
      end
      MEASURE: begin
        bus.busy    = 1'b1;
        bus.timeout = at_limit & ~fall;
      end
      CONVERT:   bus.busy = 1'b1;
      DONE:      bus.done = 1'b1;
      default:   ;
    endcase
  end

  // Synchroniser, prescaler and measurement datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_d    <= 1'b0;
      presc     <= '0;
      us_cnt    <= '0;
      rem       <= '0;
      quo       <= '0;
      echo_us_r <= '0;
      dist_cm_r <= '0;
    end else begin
      echo_meta <= bus.echo;
      echo_s    <= echo_meta;
      echo_d    <= echo_s;

      // Restarting the prescaler on accept and on rise aligns the us ticks to
      // the start of each interval being timed.
      if (accept || rise || tick) presc <= '0;
      else                        presc <= presc + PW'(1);

      unique case (state)
        IDLE, DONE: begin
          // Previous echo_us/dist_cm are kept until the next done.
          if (accept) begin
            us_cnt <= '0;
            quo    <= '0;
          end
        end
        WAIT_RISE: begin
          if (rise)                       us_cnt <= '0;
          else if (tick && !at_limit)     us_cnt <= us_cnt + W'(1);
        end
        MEASURE: begin
          if (fall) begin
            echo_us_r <= us_cnt;
            rem       <= us_cnt;
          end else if (tick && !at_limit) begin
            us_cnt <= us_cnt + W'(1);
          end
        end
        CONVERT: begin
          // Division by repeated subtraction, one step per clock.
          if (rem >= W'(CM_DIV)) begin
            rem <= rem - W'(CM_DIV);
            quo <= quo + W'(1);
          end else begin
            dist_cm_r <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_pulse_meter.sv
// tb_echo_pulse_meter
//  Self-checking bench for echo_pulse_meter. Runs with a short tick and timeout
//  so the long-range and timeout scenarios stay within a small cycle budget.
//  Expected results come from a plain arithmetic model of the ranging rules.
module tb_echo_pulse_meter;

  localparam int TICK_DIV   = 2;
  localparam int TIMEOUT_US = 6000;
  localparam int CM_DIV     = 58;
  localparam int W          = 16;
  localparam int TO_CLKS    = TIMEOUT_US * TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  echo_pulse_meter_if #(.W(W)) bus ();

  echo_pulse_meter #(
    .TICK_DIV  (TICK_DIV),
    .TIMEOUT_US(TIMEOUT_US),
    .CM_DIV    (CM_DIV),
    .W         (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Strobe counters, sampled mid-cycle.
  int done_cnt = 0;
  int to_cnt   = 0;

  // Model's view of the last valid result on echo_us/dist_cm.
  int exp_us = 0;
  int exp_cm = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done === 1'b1)    done_cnt++;
      if (bus.timeout === 1'b1) to_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: the first sampled-high clock restarts the us timebase, so
  // each complete TICK_DIV clocks after it adds one us; distance is a floor
  // division of the whole microseconds.
  function automatic int model_us(input int high_clks);
    return (high_clks - 1) / TICK_DIV;
  endfunction

  function automatic int model_cm(input int us);
    return us / CM_DIV;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_pulse(input int pre, input int high);
    repeat (pre) step();
    bus.echo = 1'b1;
    repeat (high) step();
    bus.echo = 1'b0;
  endtask

  task automatic wait_done(input bit restart, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      step();
      if (bus.done === 1'b1) ok = 1'b1;
    end
    if (ok && restart) send_start();
  endtask

  task automatic measure(input int pre, input int high, input bit restart, output bit ok);
    send_start();
    run_pulse(pre, high);
    wait_done(restart, ok);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.echo  = 1'b0;
    rst       = 1'b1;
    repeat (3) step();
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
    checks++; if (bus.echo_us !== '0)   begin errors++; $display("FAIL reset_echo_us: got %0d expected 0", bus.echo_us); end
    checks++; if (bus.dist_cm !== '0)   begin errors++; $display("FAIL reset_dist_cm: got %0d expected 0", bus.dist_cm); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  // Nominal echo widths, including both sides of the first centimetre step.
  task automatic test_nominal();
    int us_tab[5] = '{580, 57, 58, 5800, 100};
    int pre_tab[5] = '{200, 10, 10, 10, 30};
    for (int k = 0; k < 5; k++) begin
      int d0 = done_cnt;
      int t0 = to_cnt;
      int high = us_tab[k] * TICK_DIV + 1;
      bit ok;
      measure(pre_tab[k], high, 1'b0, ok);
      exp_us = model_us(high);
      exp_cm = model_cm(exp_us);
      repeat (4) step();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nominal_done_seen[%0d]: got %b expected 1", k, ok); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL nominal_done_count[%0d]: got %0d expected 1", k, done_cnt - d0); end
      checks++; if (to_cnt != t0) begin errors++; $display("FAIL nominal_no_timeout[%0d]: got %0d expected 0", k, to_cnt - t0); end
      checks++; if (bus.echo_us !== W'(exp_us)) begin errors++; $display("FAIL nominal_echo_us[%0d]: got %0d expected %0d", k, bus.echo_us, exp_us); end
      checks++; if (bus.dist_cm !== W'(exp_cm)) begin errors++; $display("FAIL nominal_dist_cm[%0d]: got %0d expected %0d", k, bus.dist_cm, exp_cm); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_after[%0d]: got %b expected 0", k, bus.busy); end
    end
  endtask

  task automatic test_no_echo();
    int d0 = done_cnt;
    int t0;
    int j = 0;
    bit seen = 1'b0;
    send_start();
    t0 = to_cnt;
    while (!seen && j < TO_CLKS + 100) begin
      step();
      j++;
      if (bus.timeout === 1'b1) seen = 1'b1;
    end
    repeat (4) step();
    checks++; if (!seen) begin errors++; $display("FAIL no_echo_timeout_seen: got 0 expected 1"); end
    checks++; if (j < TO_CLKS - TICK_DIV || j > TO_CLKS + TICK_DIV + 2) begin
      errors++; $display("FAIL no_echo_timeout_time: got %0d clks expected %0d", j, TO_CLKS);
    end
    checks++; if (to_cnt - t0 != 1) begin errors++; $display("FAIL no_echo_timeout_count: got %0d expected 1", to_cnt - t0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL no_echo_no_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (bus.echo_us !== W'(exp_us)) begin errors++; $display("FAIL no_echo_keep_us: got %0d expected %0d", bus.echo_us, exp_us); end
    checks++; if (bus.dist_cm !== W'(exp_cm)) begin errors++; $display("FAIL no_echo_keep_cm: got %0d expected %0d", bus.dist_cm, exp_cm); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_echo_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_stuck_high();
    int d0 = done_cnt;
    int t0 = to_cnt;
    int j = 0;
    int nom = TO_CLKS + 3;
    bit seen = 1'b0;
    logic busy_mid = 1'b0;
    send_start();
    repeat (5) step();
    bus.echo = 1'b1;
    while (!seen && j < TO_CLKS + 100) begin
      if (j == 100) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      j++;
      if (j == 101) busy_mid = bus.busy;
      if (bus.timeout === 1'b1) seen = 1'b1;
    end
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stuck_busy_after: got %b expected 0", bus.busy); end
    bus.echo = 1'b0;
    repeat (5) step();
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL stuck_busy_mid_start: got %b expected 1", busy_mid); end
    checks++; if (!seen) begin errors++; $display("FAIL stuck_timeout_seen: got 0 expected 1"); end
    checks++; if (j < nom - TICK_DIV || j > nom + TICK_DIV + 2) begin
      errors++; $display("FAIL stuck_timeout_time: got %0d clks expected %0d", j, nom);
    end
    checks++; if (to_cnt - t0 != 1) begin errors++; $display("FAIL stuck_timeout_count: got %0d expected 1", to_cnt - t0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL stuck_no_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (bus.echo_us !== W'(exp_us)) begin errors++; $display("FAIL stuck_keep_us: got %0d expected %0d", bus.echo_us, exp_us); end
    checks++; if (bus.dist_cm !== W'(exp_cm)) begin errors++; $display("FAIL stuck_keep_cm: got %0d expected %0d", bus.dist_cm, exp_cm); end
  endtask

  task automatic test_reset_mid();
    int high = 1160 * TICK_DIV + 1;
    bit ok;
    send_start();
    run_pulse(20, 0);
    bus.echo = 1'b1;
    repeat (200) step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); end
    #2;
    rst = 1'b1;
    #1;
    exp_us = 0;
    exp_cm = 0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.echo_us !== '0) begin errors++; $display("FAIL rstmid_echo_us: got %0d expected 0", bus.echo_us); end
    checks++; if (bus.dist_cm !== '0) begin errors++; $display("FAIL rstmid_dist_cm: got %0d expected 0", bus.dist_cm); end
    bus.echo = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    measure(15, high, 1'b0, ok);
    exp_us = model_us(high);
    exp_cm = model_cm(exp_us);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_done_seen: got %b expected 1", ok); end
    checks++; if (bus.echo_us !== W'(exp_us)) begin errors++; $display("FAIL rstmid_echo_us_after: got %0d expected %0d", bus.echo_us, exp_us); end
    checks++; if (bus.dist_cm !== W'(exp_cm)) begin errors++; $display("FAIL rstmid_dist_cm_after: got %0d expected %0d", bus.dist_cm, exp_cm); end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int high1 = 100 * TICK_DIV + 1;
    int high2 = 290 * TICK_DIV + 1;
    bit ok1;
    bit ok2;
    measure(10, high1, 1'b1, ok1);
    checks++; if (ok1 !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", ok1); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_start_accepted: busy got %b expected 1", bus.busy); end
    checks++; if (bus.dist_cm !== W'(model_cm(model_us(high1)))) begin
      errors++; $display("FAIL b2b_first_cm: got %0d expected %0d", bus.dist_cm, model_cm(model_us(high1)));
    end
    run_pulse(10, high2);
    wait_done(1'b0, ok2);
    exp_us = model_us(high2);
    exp_cm = model_cm(exp_us);
    repeat (4) step();
    checks++; if (ok2 !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", ok2); end
    checks++; if (bus.echo_us !== W'(exp_us)) begin errors++; $display("FAIL b2b_echo_us: got %0d expected %0d", bus.echo_us, exp_us); end
    checks++; if (bus.dist_cm !== W'(exp_cm)) begin errors++; $display("FAIL b2b_dist_cm: got %0d expected %0d", bus.dist_cm, exp_cm); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
  endtask

  // Random widths; the first run is a single-clock pulse (0 us, 0 cm).
  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int d0 = done_cnt;
      int high = (k == 0) ? 1 : int'($urandom_range(1200 * TICK_DIV, 2));
      int pre = int'($urandom_range(40, 0));
      bit ok;
      measure(pre, high, 1'b0, ok);
      exp_us = model_us(high);
      exp_cm = model_cm(exp_us);
      repeat (3) step();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL random_done_seen[%0d]: got %b expected 1 (high %0d clks)", k, ok, high); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL random_done_count[%0d]: got %0d expected 1", k, done_cnt - d0); end
      checks++; if (bus.echo_us !== W'(exp_us)) begin errors++; $display("FAIL random_echo_us[%0d]: got %0d expected %0d", k, bus.echo_us, exp_us); end
      checks++; if (bus.dist_cm !== W'(exp_cm)) begin errors++; $display("FAIL random_dist_cm[%0d]: got %0d expected %0d", k, bus.dist_cm, exp_cm); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.echo  = 1'b0;
    test_reset();
    test_nominal();
    test_no_echo();
    test_stuck_high();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
